// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//
// Shares the single register-file write port between two sources:
//   A : in-order pipeline writeback. No backpressure, highest priority.
//   B : long-latency results (mul/div, load miss). They arrive over a
//       valid/ready handshake and wait in a small local FIFO.
// A busy-bit scoreboard tracks destinations issued to the long-latency unit
// and stalls decode on RAW/WAW hazards. A starvation guard stops A from
// blocking B forever: it raises pipe_hold for one cycle, and that cycle
// goes to B.
//
// Parameters:
//   DEPTH      - B FIFO entries (power of 2, >= 2)
//   STARVE_MAX - cycles the B head may lose to A before a hold is forced (>= 1)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_we, a_wr, a_wd           pipeline writeback request
//   b_valid, b_ready           long-latency handshake (b_ready = FIFO not full)
//   b_wr, b_wd                 long-latency destination / data
//   iss_valid, iss_rd          issue to the long-latency unit (sets busy bit)
//   dec_rs1, dec_rs2, dec_rd   decode-stage register numbers
//   dec_stall                  decode hazard on a busy register (combinational)
//   pipe_hold                  pipeline must present a_we=0 while this is high
//   rf_we, rf_wr, rf_wd        registered register-file write port
//
// Optional feature (macro RF_WB_BYPASS_EN):
//   Adds byp1_hit/byp1_data and byp2_hit/byp2_data. These forward the
//   committing write to decode. The busy bit being cleared is also masked
//   out of the stall term in the commit cycle, which saves one stall cycle.
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a_we,
   input  logic [4:0]  a_wr,
   input  logic [31:0] a_wd,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [4:0]  b_wr,
   input  logic [31:0] b_wd,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rd,
   input  logic [4:0]  dec_rs1,
   input  logic [4:0]  dec_rs2,
   input  logic [4:0]  dec_rd,
   output logic        dec_stall,
   output logic        pipe_hold,
`ifdef RF_WB_BYPASS_EN
   output logic        byp1_hit,
   output logic [31:0] byp1_data,
   output logic        byp2_hit,
   output logic [31:0] byp2_data,
`endif
   output logic        rf_we,
   output logic [4:0]  rf_wr,
   output logic [31:0] rf_wd
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(STARVE_MAX) + 1;
   localparam logic [PW:0]   PTR_ONE     = 1;
   localparam logic [CW-1:0] CNT_ONE     = 1;
   localparam logic [CW-1:0] STARVE_LAST = CW'(STARVE_MAX - 1);

   logic [PW:0]   wr_ptr;
   logic [PW:0]   rd_ptr;
   logic [4:0]    fifo_wr [DEPTH];
   logic [31:0]   fifo_wd [DEPTH];
   logic          fifo_empty;
   logic          fifo_full;
   logic          push;
   logic          grant_b;
   logic [4:0]    head_wr;
   logic [31:0]   head_wd;
   logic [CW-1:0] starve_cnt;
   logic          rf_from_b;
   logic [31:0]   busy;
   logic [31:0]   busy_next;
   logic [31:0]   set_vec;
   logic [31:0]   clr_vec;
   logic [31:0]   busy_view;

   // The pointers carry one extra wrap bit. Equal pointers mean the FIFO is
   // empty. Equal index bits with different wrap bits mean it is full.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
   assign b_ready    = !fifo_full;
   assign push       = b_valid && !fifo_full;
   assign grant_b    = !a_we && !fifo_empty;
   assign head_wr    = fifo_wr[rd_ptr[PW-1:0]];
   assign head_wd    = fifo_wd[rd_ptr[PW-1:0]];

   // FIFO storage has no reset. The pointers alone decide which entries
   // are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_wr[wr_ptr[PW-1:0]] <= b_wr;
         fifo_wd[wr_ptr[PW-1:0]] <= b_wd;
      end
   end

   // Scoreboard next state. A commit from B clears its bit. An issue in the
   // same cycle is applied after the clear, so the set wins. x0 never
   // becomes busy.
   always_comb begin
      clr_vec = '0;
      set_vec = '0;
      if (rf_we && rf_from_b) clr_vec[rf_wr] = 1'b1;
      if (iss_valid) set_vec[iss_rd] = 1'b1;
      busy_next    = (busy & ~clr_vec) | set_vec;
      busy_next[0] = 1'b0;
   end

`ifdef RF_WB_BYPASS_EN
   // The committing register is forwarded, so it no longer has to stall.
   assign busy_view = busy & ~clr_vec;
   assign byp1_hit  = rf_we && (rf_wr == dec_rs1) && (rf_wr != 5'd0);
   assign byp2_hit  = rf_we && (rf_wr == dec_rs2) && (rf_wr != 5'd0);
   assign byp1_data = rf_wd;
   assign byp2_data = rf_wd;
`else
   assign busy_view = busy;
`endif

   assign dec_stall = busy_view[dec_rs1] | busy_view[dec_rs2] | busy_view[dec_rd];

   // Arbitration, the registered write port, the FIFO pointers, the
   // starvation guard and the busy bits, all on one clock with async reset.
   // A write to x0 still takes the grant (and pops B), but never raises
   // rf_we. The guard counts A wins while B waits. On the last allowed win
   // it raises pipe_hold for one cycle so that B gets the next grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         rf_we      <= 1'b0;
         rf_wr      <= '0;
         rf_wd      <= '0;
         rf_from_b  <= 1'b0;
         pipe_hold  <= 1'b0;
         starve_cnt <= '0;
         busy       <= '0;
      end else begin
         if (push)    wr_ptr <= wr_ptr + PTR_ONE;
         if (grant_b) rd_ptr <= rd_ptr + PTR_ONE;

         if (a_we) begin
            rf_we     <= (a_wr != 5'd0);
            rf_wr     <= a_wr;
            rf_wd     <= a_wd;
            rf_from_b <= 1'b0;
         end else if (!fifo_empty) begin
            rf_we     <= (head_wr != 5'd0);
            rf_wr     <= head_wr;
            rf_wd     <= head_wd;
            rf_from_b <= 1'b1;
         end else begin
            rf_we     <= 1'b0;
            rf_from_b <= 1'b0;
         end

         pipe_hold <= 1'b0;
         if (a_we && !fifo_empty) begin
            if (starve_cnt == STARVE_LAST) begin
               pipe_hold  <= 1'b1;
               starve_cnt <= '0;
            end else begin
               starve_cnt <= starve_cnt + CNT_ONE;
            end
         end else begin
            starve_cnt <= '0;
         end

         busy <= busy_next;
      end
   end

`ifndef SYNTHESIS
   // While pipe_hold is high the pipeline must not write back.
   a_we_during_hold: assert property (@(posedge clk) disable iff (!rst_n) pipe_hold |-> !a_we);
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// Self-checking bench for rf_wb_arbiter. The reference model is a queue of
// pending B results, a busy-bit array, and a count of how many cycles the
// B head has waited. The expected write port and hold values come from the
// arbitration rules. Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;

   localparam int DEPTH      = 4;
   localparam int STARVE_MAX = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_we = 1'b0;
   logic [4:0]  a_wr = '0;
   logic [31:0] a_wd = '0;
   logic        b_valid = 1'b0;
   logic        b_ready;
   logic [4:0]  b_wr = '0;
   logic [31:0] b_wd = '0;
   logic        iss_valid = 1'b0;
   logic [4:0]  iss_rd = '0;
   logic [4:0]  dec_rs1 = '0;
   logic [4:0]  dec_rs2 = '0;
   logic [4:0]  dec_rd = '0;
   logic        dec_stall;
   logic        pipe_hold;
   logic        rf_we;
   logic [4:0]  rf_wr;
   logic [31:0] rf_wd;
`ifdef RF_WB_BYPASS_EN
   logic        byp1_hit;
   logic [31:0] byp1_data;
   logic        byp2_hit;
   logic [31:0] byp2_data;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state.
   int          mq_wr [$];
   logic [31:0] mq_wd [$];
   bit          m_busy [32];
   int          m_wait;
   bit          m_hold;
   int          m_clr;
   logic        e_we;
   logic [4:0]  e_wr;
   logic [31:0] e_wd;

   rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_we(a_we), .a_wr(a_wr), .a_wd(a_wd),
      .b_valid(b_valid), .b_ready(b_ready), .b_wr(b_wr), .b_wd(b_wd),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
      .dec_stall(dec_stall), .pipe_hold(pipe_hold),
`ifdef RF_WB_BYPASS_EN
      .byp1_hit(byp1_hit), .byp1_data(byp1_data),
      .byp2_hit(byp2_hit), .byp2_data(byp2_data),
`endif
      .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic void model_reset();
      mq_wr.delete();
      mq_wd.delete();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_wait = 0;
      m_hold = 1'b0;
      m_clr  = 0;
      e_we   = 1'b0;
      e_wr   = '0;
      e_wd   = '0;
   endfunction

   function automatic bit m_ready();
      return mq_wr.size() < DEPTH;
   endfunction

   function automatic bit m_stall();
      return m_busy[dec_rs1] | m_busy[dec_rs2] | m_busy[dec_rd];
   endfunction

   function automatic void clear_inputs();
      a_we = 0; a_wr = 0; a_wd = 0;
      b_valid = 0; b_wr = 0; b_wd = 0;
      iss_valid = 0; iss_rd = 0;
      dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
   endfunction

   // Advance one clock edge and update the model from the inputs present at
   // that edge. Returns 1 ns after the edge, when the outputs have settled.
   task automatic step();
      bit pushing;
      int w;
      logic [31:0] d;
      @(posedge clk);
      pushing = b_valid && (mq_wr.size() < DEPTH);
      if (m_clr != 0) m_busy[m_clr] = 1'b0;
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      m_clr = 0;
      if (a_we) begin
         e_we = (a_wr != 0); e_wr = a_wr; e_wd = a_wd;
         if (mq_wr.size() > 0) begin
            if (m_wait == STARVE_MAX - 1) begin
               m_hold = 1'b1; m_wait = 0;
            end else begin
               m_hold = 1'b0; m_wait++;
            end
         end else begin
            m_hold = 1'b0; m_wait = 0;
         end
      end else if (mq_wr.size() > 0) begin
         w = mq_wr.pop_front();
         d = mq_wd.pop_front();
         e_we = (w != 0); e_wr = 5'(w); e_wd = d;
         m_clr = w;
         m_hold = 1'b0; m_wait = 0;
      end else begin
         e_we = 1'b0;
         m_hold = 1'b0; m_wait = 0;
      end
      if (pushing) begin
         mq_wr.push_back(int'(b_wr));
         mq_wd.push_back(b_wd);
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      clear_inputs();
      #3;
      n_checks++; if (rf_we !== 1'b0) $display("[TB] FAIL reset_rf_we: got %0b want 0", rf_we); else n_pass++;
      n_checks++; if (rf_wr !== 5'd0) $display("[TB] FAIL reset_rf_wr: got %0d want 0", rf_wr); else n_pass++;
      n_checks++; if (rf_wd !== 32'd0) $display("[TB] FAIL reset_rf_wd: got %h want 0", rf_wd); else n_pass++;
      n_checks++; if (pipe_hold !== 1'b0) $display("[TB] FAIL reset_hold: got %0b want 0", pipe_hold); else n_pass++;
      n_checks++; if (b_ready !== 1'b1) $display("[TB] FAIL reset_b_ready: got %0b want 1", b_ready); else n_pass++;
      n_checks++; if (dec_stall !== 1'b0) $display("[TB] FAIL reset_stall: got %0b want 0", dec_stall); else n_pass++;
      do_reset();
   endtask

   task automatic test_b_single();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         b_valid = (i == 0); b_wr = 5; b_wd = 32'hDEAD;
         #1;
         n_checks++; if (b_ready !== m_ready()) $display("[TB] FAIL bsingle_ready c%0d: got %0b want %0b", i, b_ready, m_ready()); else n_pass++;
         step();
         n_checks++; if (rf_we !== e_we) $display("[TB] FAIL bsingle_we c%0d: got %0b want %0b", i, rf_we, e_we); else n_pass++;
         if (e_we) begin
            n_checks++; if (rf_wr !== e_wr || rf_wd !== e_wd) $display("[TB] FAIL bsingle_data c%0d: got x%0d=%h want x%0d=%h", i, rf_wr, rf_wd, e_wr, e_wd); else n_pass++;
         end
      end
      n_checks++; if (rf_wr !== 5'd5 || rf_wd !== 32'hDEAD) $display("[TB] FAIL bsingle_final: got x%0d=%h want x5=0000dead", rf_wr, rf_wd); else n_pass++;
   endtask

   task automatic test_a_vs_b();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         a_we = (i == 0); a_wr = 3; a_wd = 32'h3333;
         b_valid = (i == 0); b_wr = 7; b_wd = 32'h7777;
         #1;
         step();
         n_checks++; if (rf_we !== e_we || (e_we && (rf_wr !== e_wr || rf_wd !== e_wd)))
            $display("[TB] FAIL a_vs_b c%0d: got we=%0b x%0d=%h want we=%0b x%0d=%h", i, rf_we, rf_wr, rf_wd, e_we, e_wr, e_wd); else n_pass++;
      end
   endtask

   task automatic test_starvation();
      int holds;
      holds = 0;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         a_we = !m_hold; a_wr = 5'(1 + (i % 30)); a_wd = 32'(i);
         b_valid = (i < 5); b_wr = 5'(10 + i); b_wd = 32'hB000 + 32'(i);
         #1;
         n_checks++; if (b_ready !== m_ready()) $display("[TB] FAIL starve_ready c%0d: got %0b want %0b", i, b_ready, m_ready()); else n_pass++;
         step();
         if (pipe_hold === 1'b1) holds++;
         n_checks++; if (pipe_hold !== m_hold) $display("[TB] FAIL starve_hold c%0d: got %0b want %0b", i, pipe_hold, m_hold); else n_pass++;
         n_checks++; if (rf_we !== e_we || rf_wr !== e_wr || rf_wd !== e_wd)
            $display("[TB] FAIL starve_wr c%0d: got we=%0b x%0d=%h want we=%0b x%0d=%h", i, rf_we, rf_wr, rf_wd, e_we, e_wr, e_wd); else n_pass++;
      end
      n_checks++; if (holds !== 2) $display("[TB] FAIL starve_hold_count: got %0d want 2", holds); else n_pass++;
   endtask

   task automatic test_scoreboard();
      do_reset();
      iss_valid = 1; iss_rd = 9; dec_rs1 = 9;
      #1;
      step();
      iss_valid = 0;
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) begin
            iss_valid = 1; iss_rd = 9;
            #1;
            step();
            iss_valid = 0;
         end
         for (int i = 0; i < 8; i++) begin
            b_valid = (i == 1); b_wr = 9; b_wd = $urandom;
            iss_valid = (pass == 1) && (m_clr == 9); iss_rd = 9;
            #1;
            n_checks++; if (dec_stall !== m_stall()) $display("[TB] FAIL sb_stall p%0d c%0d: got %0b want %0b", pass, i, dec_stall, m_stall()); else n_pass++;
            step();
         end
         iss_valid = 0; b_valid = 0;
         #1;
         n_checks++; if (dec_stall !== (pass == 1)) $display("[TB] FAIL sb_final p%0d: got %0b want %0b", pass, dec_stall, pass == 1); else n_pass++;
      end
   endtask

   task automatic test_x0();
      do_reset();
      iss_valid = 1; iss_rd = 6; dec_rd = 6;
      #1;
      step();
      iss_valid = 0;
      for (int i = 0; i < 6; i++) begin
         b_valid = (i == 0); b_wr = 0; b_wd = 32'h1234;
         a_we = (i == 4); a_wr = 0; a_wd = 32'h5678;
         #1;
         step();
         n_checks++; if (rf_we !== 1'b0) $display("[TB] FAIL x0_we c%0d: got %0b want 0", i, rf_we); else n_pass++;
      end
      n_checks++; if (b_ready !== 1'b1 || mq_wr.size() != 0) $display("[TB] FAIL x0_popped: b_ready %0b want 1, model depth %0d", b_ready, mq_wr.size()); else n_pass++;
      n_checks++; if (dec_stall !== 1'b1) $display("[TB] FAIL x0_busy_kept: got %0b want 1", dec_stall); else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         a_we = 1; a_wr = 2; a_wd = 32'(i);
         b_valid = (i < 3); b_wr = 5'(20 + i); b_wd = 32'(i);
         iss_valid = (i == 0); iss_rd = 4;
         #1;
         step();
      end
      clear_inputs();
      dec_rs1 = 4;
      #1;
      n_checks++; if (rf_we !== 1'b1 || b_ready !== m_ready() || dec_stall !== 1'b1)
         $display("[TB] FAIL rstmid_pre: we=%0b ready=%0b stall=%0b want 1 %0b 1", rf_we, b_ready, dec_stall, m_ready()); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++; if (b_ready !== 1'b1) $display("[TB] FAIL rstmid_ready: got %0b want 1", b_ready); else n_pass++;
      n_checks++; if (dec_stall !== 1'b0) $display("[TB] FAIL rstmid_stall: got %0b want 0", dec_stall); else n_pass++;
      n_checks++; if (rf_we !== 1'b0) $display("[TB] FAIL rstmid_we: got %0b want 0", rf_we); else n_pass++;
      do_reset();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         a_we = m_hold ? 1'b0 : ($urandom_range(0, 9) < 6);
         a_wr = 5'($urandom); a_wd = $urandom;
         b_valid = $urandom_range(0, 1); b_wr = 5'($urandom); b_wd = $urandom;
         iss_valid = ($urandom_range(0, 3) == 0); iss_rd = 5'($urandom);
         dec_rs1 = 5'($urandom); dec_rs2 = 5'($urandom); dec_rd = 5'($urandom);
         #1;
         n_checks++; if (b_ready !== m_ready() || dec_stall !== m_stall())
            $display("[TB] FAIL rand_comb c%0d: ready=%0b stall=%0b want %0b %0b", i, b_ready, dec_stall, m_ready(), m_stall()); else n_pass++;
         step();
         n_checks++; if (rf_we !== e_we || rf_wr !== e_wr || rf_wd !== e_wd || pipe_hold !== m_hold)
            $display("[TB] FAIL rand_seq c%0d: we=%0b x%0d=%h hold=%0b want we=%0b x%0d=%h hold=%0b",
                     i, rf_we, rf_wr, rf_wd, pipe_hold, e_we, e_wr, e_wd, m_hold); else n_pass++;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_b_single();
      test_a_vs_b();
      test_starvation();
      test_scoreboard();
      test_x0();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
